// File: rtl/excute_pkg.sv
// ---------------------------------------------------------------------------
// excute_pkg
//   Shared constants for the execute stage of the in-order CPU pipeline:
//   the 3-bit operation encodings, the default datapath width, the position
//   of the "taken" flag inside the branch/jump bus, and the link increment
//   used by JAL.
// ---------------------------------------------------------------------------
package excute_pkg;

  // Default datapath width (operands, PC, ALU result, branch target).
  localparam int XLEN = 32;

  // Operation encodings presented on the Op input. All 8 codes are legal.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_BEQZ = 3'b110;
  localparam logic [2:0] OP_JAL  = 3'b111;

  // BjBus layout: {taken, target[XLEN-1:0]}; the taken flag sits just above
  // the target field.
  localparam int BJ_TAKEN_BIT = XLEN;

  // Return address of JAL is the next sequential instruction.
  localparam int LINK_INC = 4;

endpackage : excute_pkg

// File: rtl/excute_alu.sv
// ---------------------------------------------------------------------------
// excute_alu
//   Purely combinational datapath of the execute stage. Computes the ALU or
//   link result, the branch-taken decision and the branch/jump target for
//   the instruction currently in the stage. The target is always PC+S2; the
//   fetch stage only uses it when taken_d is set.
//
// Ports
//   Op        in   3     operation select (see excute_pkg OP_*)
//   S1        in   BITS  operand 1 (also the BEQZ test value)
//   S2        in   BITS  operand 2 / branch-jump offset
//   PC        in   BITS  PC of the instruction in this stage
//   alu_d     out  BITS  ALU / link result (next value of AluResult)
//   taken_d   out  1     branch/jump taken
//   target_d  out  BITS  branch/jump target, wraps modulo 2^BITS
// ---------------------------------------------------------------------------
module excute_alu
  import excute_pkg::*;
#(
  parameter int BITS = XLEN
) (
  input  logic [2:0]      Op,
  input  logic [BITS-1:0] S1,
  input  logic [BITS-1:0] S2,
  input  logic [BITS-1:0] PC,
  output logic [BITS-1:0] alu_d,
  output logic            taken_d,
  output logic [BITS-1:0] target_d
);

  logic [BITS-1:0] pc_plus_off;
  logic [BITS-1:0] pc_link;
  logic            s1_lt_s2;
  logic            s1_is_zero;

  // Additions are carried out at BITS width, so carries drop out naturally.
  assign pc_plus_off = PC + S2;
  assign pc_link     = PC + BITS'(LINK_INC);
  assign s1_lt_s2    = $signed(S1) < $signed(S2);
  assign s1_is_zero  = (S1 == '0);

  // The target field is independent of the op; it is qualified by taken_d.
  assign target_d = pc_plus_off;

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_d   = '0;
    taken_d = 1'b0;
    case (Op)
      OP_ADD:  alu_d = S1 + S2;
      OP_SUB:  alu_d = S1 - S2;
      OP_AND:  alu_d = S1 & S2;
      OP_OR:   alu_d = S1 | S2;
      OP_XOR:  alu_d = S1 ^ S2;
      OP_SLT:  alu_d = {{(BITS-1){1'b0}}, s1_lt_s2};
      OP_BEQZ: begin
        alu_d   = pc_plus_off;
        taken_d = s1_is_zero;
      end
      OP_JAL:  begin
        alu_d   = pc_link;
        taken_d = 1'b1;
      end
      default: begin
        alu_d   = '0;
        taken_d = 1'b0;
      end
    endcase
  end

endmodule : excute_alu

// File: rtl/excute_stage.sv
// ---------------------------------------------------------------------------
// excute_stage
//   Execute stage of the simple in-order CPU pipeline. Sits between
//   decode/register-read and memory/writeback. A new op is accepted every
//   cycle; both outputs are registered, giving a fixed 1-cycle latency with
//   no handshake. BjBus feeds the fetch stage's PC-redirect logic.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset, clears outputs
//   Op         in   3       operation select (see excute_pkg OP_*)
//   S1         in   BITS    operand 1
//   S2         in   BITS    operand 2 / branch-jump offset
//   PC         in   BITS    PC of the instruction in this stage
//   AluResult  out  BITS    registered ALU / link result
//   BjBus      out  BITS+1  registered {taken, target}
// ---------------------------------------------------------------------------
module excute_stage
  import excute_pkg::*;
#(
  parameter int BITS = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      Op,
  input  logic [BITS-1:0] S1,
  input  logic [BITS-1:0] S2,
  input  logic [BITS-1:0] PC,
  output logic [BITS-1:0] AluResult,
  output logic [BITS:0]   BjBus
);

  logic [BITS-1:0] alu_d;
  logic            taken_d;
  logic [BITS-1:0] target_d;
  logic [BITS:0]   bj_d;

  logic [BITS-1:0] alu_q;
  logic [BITS:0]   bj_q;

  excute_alu #(
    .BITS(BITS)
  ) u_alu (
    .Op      (Op),
    .S1      (S1),
    .S2      (S2),
    .PC      (PC),
    .alu_d   (alu_d),
    .taken_d (taken_d),
    .target_d(target_d)
  );

  // Taken flag occupies the top bit, directly above the target.
  assign bj_d = {taken_d, target_d};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q <= '0;
      bj_q  <= '0;
    end else begin
      alu_q <= alu_d;
      bj_q  <= bj_d;
    end
  end

  assign AluResult = alu_q;
  assign BjBus     = bj_q;

endmodule : excute_stage

// File: tb/tb_excute_stage.sv
// ---------------------------------------------------------------------------
// tb_excute_stage
//   Self-checking bench for excute_stage. A table of vectors holds inputs
//   and hand-derived expected outputs; each vector is driven on a falling
//   edge and its expectation pushed to a scoreboard queue. A monitor pops
//   and compares one entry shortly after each rising edge. Reset behaviour
//   (initial and mid-stream) is checked by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_excute_stage;
  import excute_pkg::*;

  localparam int BITS = XLEN;

  typedef struct {
    logic [2:0]      op;
    logic [BITS-1:0] s1;
    logic [BITS-1:0] s2;
    logic [BITS-1:0] pc;
    logic [BITS-1:0] exp_alu;
    logic [BITS:0]   exp_bj;
  } vec_t;

  typedef struct packed {
    int              tag;
    logic [BITS-1:0] alu;
    logic [BITS:0]   bj;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      Op = '0;
  logic [BITS-1:0] S1 = '0;
  logic [BITS-1:0] S2 = '0;
  logic [BITS-1:0] PC = '0;
  logic [BITS-1:0] AluResult;
  logic [BITS:0]   BjBus;

  int   checks = 0;
  int   errors = 0;
  int   tag_cnt = 0;
  exp_t sb[$];
  vec_t vecs[$];

  excute_stage #(.BITS(BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Op       (Op),
    .S1       (S1),
    .S2       (S2),
    .PC       (PC),
    .AluResult(AluResult),
    .BjBus    (BjBus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BITS:0] act,
                       input logic [BITS:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op on the falling edge and record what must appear after the
  // following rising edge.
  task automatic drive(input logic [2:0] op, input logic [BITS-1:0] s1,
                       input logic [BITS-1:0] s2, input logic [BITS-1:0] pc,
                       input logic [BITS-1:0] exp_alu,
                       input logic [BITS:0] exp_bj);
    exp_t e;
    @(negedge clk);
    Op = op;
    S1 = s1;
    S2 = s2;
    PC = pc;
    e.tag = tag_cnt;
    e.alu = exp_alu;
    e.bj  = exp_bj;
    sb.push_back(e);
    tag_cnt++;
  endtask

  // Scoreboard monitor: compare just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sb.size() != 0) begin
      e = sb.pop_front();
      check($sformatf("op%0d_alu", e.tag), {1'b0, AluResult}, {1'b0, e.alu});
      check($sformatf("op%0d_bj", e.tag), BjBus, e.bj);
    end
  end

  initial begin
    int n;

    // ---- reset held with random inputs ----
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Op = 3'($urandom_range(0, 7));
      S1 = $urandom;
      S2 = $urandom;
      PC = $urandom;
      #2;
      check($sformatf("rst%0d_alu", i), {1'b0, AluResult}, '0);
      check($sformatf("rst%0d_bj", i), BjBus, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven vectors (target field is always PC+S2) ----
    vecs.push_back('{OP_ADD,  32'h2,        32'h3,        32'h0,        32'h5,        33'h0_0000_0003});
    vecs.push_back('{OP_SUB,  32'h3,        32'h4,        32'h0,        32'hFFFFFFFF, 33'h0_0000_0004});
    vecs.push_back('{OP_AND,  32'h4,        32'h5,        32'h0,        32'h4,        33'h0_0000_0005});
    vecs.push_back('{OP_OR,   32'h5,        32'h6,        32'h0,        32'h7,        33'h0_0000_0006});
    vecs.push_back('{OP_XOR,  32'h6,        32'h7,        32'h0,        32'h1,        33'h0_0000_0007});
    vecs.push_back('{OP_SLT,  32'h7,        32'h8,        32'h0,        32'h1,        33'h0_0000_0008});
    vecs.push_back('{OP_BEQZ, 32'h8,        32'h9,        32'h18,       32'h21,       33'h0_0000_0021});
    vecs.push_back('{OP_BEQZ, 32'h0,        32'h9,        32'h18,       32'h21,       33'h1_0000_0021});
    vecs.push_back('{OP_JAL,  32'h9,        32'hA,        32'h1C,       32'h20,       33'h1_0000_0026});
    vecs.push_back('{OP_SLT,  32'h80000000, 32'h1,        32'h0,        32'h1,        33'h0_0000_0001});
    vecs.push_back('{OP_SLT,  32'h1,        32'h80000000, 32'h0,        32'h0,        33'h0_8000_0000});
    vecs.push_back('{OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        33'h0_0000_0001});
    vecs.push_back('{OP_JAL,  32'h0,        32'h8,        32'hFFFFFFFC, 32'h0,        33'h1_0000_0004});
    vecs.push_back('{OP_SUB,  32'hA,        32'h3,        32'h100,      32'h7,        33'h0_0000_0103});
    vecs.push_back('{OP_BEQZ, 32'h1,        32'hFFFFFFF0, 32'h40,       32'h30,       33'h0_0000_0030});

    foreach (vecs[i])
      drive(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].pc,
            vecs[i].exp_alu, vecs[i].exp_bj);

    // ---- mid-stream asynchronous reset ----
    drive(OP_JAL, 32'h0, 32'hA, 32'h1C, 32'h20, 33'h1_0000_0026);
    drive(OP_ADD, 32'h2, 32'h3, 32'h0,  32'h5,  33'h0_0000_0003);
    // The ADD is pending; reset lands between edges and discards it.
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_async_alu", {1'b0, AluResult}, '0);
    check("midrst_async_bj", BjBus, '0);
    @(posedge clk);
    #1;
    check("midrst_hold_alu", {1'b0, AluResult}, '0);
    check("midrst_hold_bj", BjBus, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(OP_ADD, 32'h2, 32'h3, 32'h0, 32'h5, 33'h0_0000_0003);
    drive(OP_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 32'h8, 32'h0F0FF0F0, 33'h0_FFFF_0008);

    // ---- drain scoreboard with a bounded wait ----
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #3;
    check("scoreboard_drained", 33'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_excute_stage
